// File: rtl/matrix_job_sequencer.sv
// Bus-master sequencer: fetches 64 operand words into the matrix accelerator, starts it, waits
// for done (bounded by a timeout), then copies 32 results back. Memory stalls via waitrequest hold the current beat.
module matrix_job_sequencer #(
  parameter int Width         = 32,
  parameter int TimeoutCycles = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctl_write,
  input  logic             ctl_read,
  input  logic [1:0]       ctl_address,
  input  logic [Width-1:0] ctl_writedata,
  output logic [Width-1:0] ctl_readdata,
  output logic [Width-1:0] mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [Width-1:0] mem_writedata,
  input  logic [Width-1:0] mem_readdata,
  input  logic             mem_waitrequest,
  output logic [8:0]       acc_address,
  output logic             acc_write,
  output logic             acc_read,
  output logic [Width-1:0] acc_writedata,
  input  logic [Width-1:0] acc_readdata,
  input  logic             acc_done,
  output logic             irq
);
  localparam int TW = $clog2(TimeoutCycles) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_PUSH, S_START, S_WAIT, S_PULL, S_STORE, S_ACK, S_FIN, S_ERR
  } state_e;

  state_e           state_q;
  logic [Width-1:0] src_q, dst_q, wsrc_q, wdst_q, data_q, cycles_q;
  logic [Width-1:0] mem_address_q, acc_writedata_q;
  logic [8:0]       acc_address_q;
  logic [6:0]       idx_q, idx_inc;
  logic [TW-1:0]    tmo_q;
  logic             done_q, err_q, irq_q;
  logic             mem_read_q, mem_write_q, acc_write_q, acc_read_q;
  logic             busy, ctrl_wr, go, clr;

  function automatic logic [Width-1:0] woff(input logic [6:0] i);
    return {{(Width-9){1'b0}}, i, 2'b00};
  endfunction

  assign busy    = (state_q != S_IDLE);
  assign idx_inc = idx_q + 7'd1;
  assign ctrl_wr = ctl_write && (ctl_address == 2'd2);
  assign go      = ctrl_wr && ctl_writedata[0];
  assign clr     = ctrl_wr && ctl_writedata[1];

  assign mem_address   = mem_address_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_writedata = data_q;
  assign acc_address   = acc_address_q;
  assign acc_write     = acc_write_q;
  assign acc_read      = acc_read_q;
  assign acc_writedata = acc_writedata_q;
  assign irq           = irq_q;

  always_comb begin
    ctl_readdata = '0;
    if (ctl_read) begin
      case (ctl_address)
        2'd0:    ctl_readdata = src_q;
        2'd1:    ctl_readdata = dst_q;
        2'd2:    ctl_readdata = {{(Width-15){1'b0}}, idx_q, 5'b00000, err_q, done_q, busy};
        default: ctl_readdata = cycles_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      src_q           <= '0;
      dst_q           <= '0;
      wsrc_q          <= '0;
      wdst_q          <= '0;
      data_q          <= '0;
      cycles_q        <= '0;
      mem_address_q   <= '0;
      acc_writedata_q <= '0;
      acc_address_q   <= '0;
      idx_q           <= '0;
      tmo_q           <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      irq_q           <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      acc_write_q     <= 1'b0;
      acc_read_q      <= 1'b0;
    end else begin
      // Register writes land even mid-job; the running job uses its working copies.
      if (ctl_write && ctl_address == 2'd0) src_q <= {ctl_writedata[Width-1:2], 2'b00};
      if (ctl_write && ctl_address == 2'd1) dst_q <= {ctl_writedata[Width-1:2], 2'b00};
      if (clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        irq_q  <= 1'b0;
        if (!busy) idx_q <= '0;
      end
      if (busy && cycles_q != '1) cycles_q <= cycles_q + Width'(1);

      // Bus outputs are set on the edge entering the state that owns them.
      case (state_q)
        S_IDLE: if (go) begin
          wsrc_q        <= src_q;
          wdst_q        <= dst_q;
          idx_q         <= '0;
          cycles_q      <= '0;
          mem_address_q <= src_q;
          mem_read_q    <= 1'b1;
          state_q       <= S_FETCH;
        end
        S_FETCH: if (!mem_waitrequest) begin
          mem_read_q      <= 1'b0;
          acc_write_q     <= 1'b1;
          acc_address_q   <= {2'b00, idx_q};
          acc_writedata_q <= mem_readdata;
          state_q         <= S_PUSH;
        end
        S_PUSH: begin
          idx_q <= idx_inc;
          if (idx_inc == 7'd64) begin
            acc_address_q   <= 9'd64;
            acc_writedata_q <= Width'(1);
            state_q         <= S_START;
          end else begin
            acc_write_q   <= 1'b0;
            mem_read_q    <= 1'b1;
            mem_address_q <= wsrc_q + woff(idx_inc);
            state_q       <= S_FETCH;
          end
        end
        S_START: begin
          acc_write_q <= 1'b0;
          tmo_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (acc_done) begin
            idx_q         <= '0;
            acc_read_q    <= 1'b1;
            acc_address_q <= 9'd128;
            state_q       <= S_PULL;
          end else if (tmo_q == TW'(TimeoutCycles - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_PULL: begin
          acc_read_q    <= 1'b0;
          data_q        <= acc_readdata;
          mem_write_q   <= 1'b1;
          mem_address_q <= wdst_q + woff(idx_q);
          state_q       <= S_STORE;
        end
        S_STORE: if (!mem_waitrequest) begin
          mem_write_q <= 1'b0;
          idx_q       <= idx_inc;
          if (idx_inc == 7'd32) begin
            acc_write_q     <= 1'b1;
            acc_address_q   <= 9'd256;
            acc_writedata_q <= Width'(1);
            state_q         <= S_ACK;
          end else begin
            acc_read_q    <= 1'b1;
            acc_address_q <= 9'd128 + {2'b00, idx_inc};
            state_q       <= S_PULL;
          end
        end
        S_ACK: begin
          acc_write_q <= 1'b0;
          done_q      <= 1'b1;
          irq_q       <= 1'b1;
          state_q     <= S_FIN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_job_sequencer.sv
// Scoreboarded bench: memory/accelerator models, randomized stalls and jobs, expected bus trace per job.
module tb_matrix_job_sequencer;
  localparam logic [1:0] K_MRD = 2'd0, K_MWR = 2'd1, K_AWR = 2'd2, K_ARD = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk, reset_n, ctl_write, ctl_read;
  logic [1:0]  ctl_address;
  logic [31:0] ctl_writedata, ctl_readdata, mem_address, mem_writedata, mem_readdata;
  logic [31:0] acc_writedata, acc_readdata;
  logic        mem_read, mem_write, mem_waitrequest, acc_write, acc_read, acc_done, irq;
  logic [8:0]  acc_address;

  int checks = 0;
  int fails = 0;
  int stall_cnt = 0;
  int stall_left = 0;
  bit rand_wait = 0;
  int done_delay = 10;
  bit done_pre = 0;
  int done_cnt;
  txn_t exp_q[$];
  logic [31:0] rom [0:4095];
  logic [31:0] acc_op [0:63];

  matrix_job_sequencer #(.Width(32), .TimeoutCycles(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ctl_write(ctl_write), .ctl_read(ctl_read), .ctl_address(ctl_address),
    .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
    .acc_address(acc_address), .acc_write(acc_write), .acc_read(acc_read),
    .acc_writedata(acc_writedata), .acc_readdata(acc_readdata), .acc_done(acc_done), .irq(irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory: read-only operand store, stalls of 0..3 cycles per transfer when enabled
  assign mem_readdata    = rom[mem_address[13:2]];
  assign mem_waitrequest = (mem_read || mem_write) && (stall_left > 0);
  always @(posedge clk)
    if (mem_read || mem_write) begin
      if (stall_left > 0) stall_left <= stall_left - 1;
      else stall_left <= rand_wait ? int'($urandom_range(0, 3)) : 0;
    end

  // Accelerator: result j = op[j] * op[j+32] + j; done after a programmable WAIT length
  assign acc_readdata = acc_op[{1'b0, acc_address[4:0]}] * acc_op[{1'b1, acc_address[4:0]}]
                        + {27'd0, acc_address[4:0]};
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc_done <= 1'b0;
      done_cnt <= 0;
    end else begin
      if (acc_write && acc_address < 9'd64) acc_op[acc_address[5:0]] <= acc_writedata;
      if (acc_write && acc_address == 9'd256) acc_done <= 1'b0;
      else if (done_pre) acc_done <= 1'b1;
      else if (acc_write && acc_address == 9'd64 && done_delay > 0) begin
        if (done_delay == 1) acc_done <= 1'b1;
        else done_cnt <= done_delay - 1;
      end else if (done_cnt > 0) begin
        done_cnt <= done_cnt - 1;
        if (done_cnt == 1) acc_done <= 1'b1;
      end
    end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic got(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
    txn_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL sb_unexpected actual kind=%0d addr=%0h data=%0h, required none", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      check("sb_addr", addr, e.addr);
      if (kind == K_MWR || kind == K_AWR) check("sb_data", data, e.data);
    end
  endtask

  // Monitor: pops the scoreboard on every completed bus transfer
  bit          prev_stall = 0, ack_prev = 0;
  logic [65:0] prev_vec;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
      ack_prev   = 0;
    end else begin
      if (mem_read || mem_write || acc_read || acc_write)
        check("one_strobe", (32'(mem_read) + 32'(mem_write) + 32'(acc_read) + 32'(acc_write)) > 1, 0);
      if (prev_stall) check("stall_stable", {mem_address, mem_writedata, mem_read, mem_write}, prev_vec);
      prev_stall = (mem_read || mem_write) && mem_waitrequest;
      prev_vec   = {mem_address, mem_writedata, mem_read, mem_write};
      if (prev_stall) stall_cnt++;
      if (mem_read && !mem_waitrequest) got(K_MRD, mem_address, 32'd0);
      if (mem_write && !mem_waitrequest) got(K_MWR, mem_address, mem_writedata);
      if (acc_write) got(K_AWR, {23'd0, acc_address}, acc_writedata);
      if (acc_read) got(K_ARD, {23'd0, acc_address}, 32'd0);
      if (ack_prev) check("irq_after_ack", irq, 1);
      ack_prev = acc_write && acc_address == 9'd256;
      if (ack_prev) check("irq_at_ack", irq, 0);
    end
  end

  task automatic push_job(input logic [31:0] src, input logic [31:0] dst, input bit tmo);
    logic [31:0] w [0:63];
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      a = src + 32'(4 * i);
      w[i] = rom[a[13:2]];
      exp_q.push_back('{K_MRD, a, 32'd0});
      exp_q.push_back('{K_AWR, 32'(i), w[i]});
    end
    exp_q.push_back('{K_AWR, 32'd64, 32'd1});
    if (!tmo) begin
      for (int j = 0; j < 32; j++) begin
        exp_q.push_back('{K_ARD, 32'(128 + j), 32'd0});
        exp_q.push_back('{K_MWR, dst + 32'(4 * j), w[j] * w[j + 32] + 32'(j)});
      end
      exp_q.push_back('{K_AWR, 32'd256, 32'd1});
    end
  endtask

  task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
    ctl_write = 1; ctl_address = a; ctl_writedata = d;
    @(negedge clk);
    ctl_write = 0;
  endtask

  task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
    ctl_read = 1; ctl_address = a;
    #1 d = ctl_readdata;
    ctl_read = 0;
  endtask

  task automatic go();
    ctl_wr(2'd2, 32'd1);
    check("go_latency", mem_read, 1);
  endtask

  task automatic wait_finish(input logic [31:0] exp_status, input int exp_busy, input int sbase);
    logic [31:0] d;
    int c = 0;
    while (!irq && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("irq_rise", irq, 1);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    ctl_rd(2'd2, d); check("status", d, exp_status);
    ctl_rd(2'd3, d); check("cycles", d, 32'(exp_busy + stall_cnt - sbase));
    ctl_wr(2'd2, 32'd2);
    ctl_rd(2'd2, d); check("status_clr", {d, irq}, 33'd0);
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int delay,
                         input bit pre, input bit tmo);
    int sb;
    ctl_wr(2'd0, src);
    ctl_wr(2'd1, dst);
    done_delay = delay;
    done_pre   = pre;
    push_job(src & ~32'h3, dst & ~32'h3, tmo);
    if (pre) repeat (2) @(negedge clk);
    sb = stall_cnt;
    go();
    wait_finish(tmo ? 32'h4006 : 32'h2002, tmo ? 146 : 195 + (pre ? 1 : delay), sb);
    done_pre = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int sb, c;
    for (int i = 0; i < 4096; i++) rom[i] = $urandom;
    for (int i = 0; i < 64; i++) rom[12'h400 + i] = 32'(i);
    for (int i = 0; i < 64; i++) acc_op[i] = 32'd0;
    reset_n = 0; ctl_write = 0; ctl_read = 0; ctl_address = 0; ctl_writedata = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ctl_readdata, mem_address, mem_read, mem_write, mem_writedata,
                            acc_address, acc_write, acc_read, acc_writedata, irq}, 0);
    reset_n = 1;
    @(negedge clk);
    ctl_rd(2'd2, d); check("reset_status", d, 0);
    ctl_rd(2'd3, d); check("reset_cycles", d, 0);
    ctl_wr(2'd0, 32'h0000_1003);
    ctl_rd(2'd0, d); check("src_align", d, 32'h0000_1000);

    // Directed job: zero-wait memory, WAIT of 10 cycles
    run_job(32'h0000_1000, 32'h0000_2000, 10, 0, 0);

    // Random stalls, random addresses, one job that wraps the 32-bit address space
    rand_wait = 1;
    for (int r = 0; r < 3; r++)
      run_job(32'h1000_0000 | ($urandom & 32'h3FFF), $urandom, $urandom_range(1, 15), 0, 0);
    run_job(32'hFFFF_FFF0, 32'hFFFF_FFC0, 5, 0, 0);

    // Accelerator never finishes: timeout path, no ACK write
    run_job(32'h0000_1800, 32'h0000_2000, 0, 0, 1);

    // GO and SRC written while busy
    rand_wait = 0;
    ctl_wr(2'd0, 32'h0000_1000);
    ctl_wr(2'd1, 32'h0000_2400);
    done_delay = 10;
    push_job(32'h0000_1000, 32'h0000_2400, 0);
    sb = stall_cnt;
    go();
    repeat (40) @(negedge clk);
    ctl_wr(2'd0, 32'h0000_3000);
    ctl_wr(2'd2, 32'd1);
    ctl_rd(2'd0, d); check("src_midjob", d, 32'h0000_3000);
    wait_finish(32'h2002, 205, sb);
    repeat (20) @(negedge clk);
    push_job(32'h0000_3000, 32'h0000_2400, 0);
    sb = stall_cnt;
    go();
    wait_finish(32'h2002, 205, sb);

    // Reset while storing results
    ctl_wr(2'd1, 32'h0000_2800);
    push_job(32'h0000_3000, 32'h0000_2800, 0);
    go();
    c = 0;
    while (!mem_write && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("reached_store", mem_write, 1);
    #2 reset_n = 0;
    #1 check("reset_midjob", {ctl_readdata, mem_address, mem_read, mem_write, mem_writedata,
                              acc_address, acc_write, acc_read, acc_writedata, irq}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    ctl_rd(2'd2, d); check("status_after_reset", d, 0);
    run_job(32'h0000_1000, 32'h0000_2C00, 10, 0, 0);

    // Done already high before START
    rand_wait = 1;
    run_job(32'h0000_2000, 32'h0000_3400, 0, 1, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/matrix_job_sequencer.md
# matrix_job_sequencer

Avalon-MM bus-master sequencer that runs one complete 4x4 complex matrix-multiply job on the matrix accelerator without CPU data movement. It fetches the 64 operand words from system memory, writes them into the accelerator's slave port, triggers the multiply, waits for the accelerator done line, and copies the 32 result words back to memory. It sits between the system interconnect and the accelerator slave port. The CPU sees it only through a 4-register control slave and an interrupt.

## Interface
- Width, 32, data width of all buses
- TimeoutCycles, 4096, maximum cycles spent in WAIT before flagging an error
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- ctl_write / ctl_read  in  1  control slave strobes
- ctl_address  in  2  register index: 0 SRC, 1 DST, 2 CTRL/STATUS, 3 CYCLES
- ctl_writedata  in  32  control write data
- ctl_readdata  out  32  control read data, combinational on ctl_read, 0 otherwise
- mem_address  out  32  byte address to system memory
- mem_read / mem_write  out  1  memory master strobes
- mem_writedata  out  32  result word being stored
- mem_readdata  in  32  operand word, valid when mem_read && !mem_waitrequest
- mem_waitrequest  in  1  memory stall
- acc_address  out  9  accelerator slave address
- acc_write / acc_read  out  1  accelerator strobes; single-cycle, no waitrequest
- acc_writedata  out  32  word written to the accelerator
- acc_readdata  in  32  accelerator read data, valid in the same cycle as acc_read
- acc_done  in  1  accelerator done line; level, held until acknowledged
- irq  out  1  job-finished interrupt, level

## Operation
- Accelerator map:
  - Operand words go to addresses 0..63 in memory order.
  - Start is a write of 1 to address 64.
  - Results are read from addresses 128..159.
  - Done is acknowledged by a write of 1 to address 256.
- Control registers:
  - SRC and DST are byte addresses; bits [1:0] are ignored and read as 0.
  - CTRL write: bit0 GO, bit1 CLR (clears DONE, ERR and irq).
  - STATUS read: bit0 BUSY, bit1 DONE, bit2 ERR, bits[14:8] word index i.
  - CYCLES reads the cycle count from GO to finish of the last job.
- States: IDLE, FETCH, PUSH, START, WAIT, PULL, STORE, ACK, FIN, ERR.
- IDLE: GO latches SRC/DST into working registers, clears the index, clears CYCLES, goes to FETCH. GO while BUSY is ignored. SRC/DST writes while BUSY are accepted but do not affect the running job.
- FETCH: mem_read=1 at SRC+4i, held until !mem_waitrequest. The word is captured that cycle, then go to PUSH.
- PUSH: one-cycle acc_write at address i. Then i++; if i==64 go to START, else FETCH.
- START: one-cycle acc_write to address 64, data 1. Go to WAIT.
- WAIT: exit to PULL when acc_done=1, resetting i to 0. The timeout counter increments each WAIT cycle; reaching TimeoutCycles goes to ERR.
- PULL: one-cycle acc_read at 128+i, capturing acc_readdata into the write-data register.
- STORE: mem_write=1 at DST+4i, held until !mem_waitrequest. Then i++; if i==32 go to ACK, else PULL.
- ACK: one-cycle acc_write to address 256, data 1. Go to FIN.
- FIN: set DONE, set irq, return to IDLE.
- ERR: set ERR, DONE and irq; return to IDLE with no ACK write.
- BUSY=1 in every state except IDLE.
- CYCLES increments every BUSY cycle and saturates at 0xFFFFFFFF.
- Addresses wrap modulo 2^32.
- CLR and GO written in the same word: CLR is applied first, then GO is evaluated.

## Timing
- Reset: every output and register goes to 0 and the state goes to IDLE immediately, asynchronously. Reset mid-job aborts with no further bus cycles.
- A GO write at edge t gives mem_read=1 from cycle t+1.
- Only one bus strobe is active at a time; acc_* strobes are always exactly 1 cycle.
- Zero-wait memory: 2 cycles per operand word, 128 for the load.
  - START is 1 cycle, WAIT takes N cycles, PULL/STORE take 64 cycles, ACK is 1, FIN is 1.
  - irq rises 1 cycle after the ACK write.
- Each mem_waitrequest cycle adds exactly 1 cycle, with address and data held stable.
- acc_done already high on entry to WAIT exits WAIT after 1 cycle.

## Test plan
- Zero-wait memory, SRC=0x1000 with words 0..63, DST=0x2000, acc_done raised 10 cycles after start. Required:
  - 64 acc_writes with address = data index.
  - Write of 1 to address 64.
  - 32 reads at 128..159 copied to 0x2000..0x207C.
  - Write to address 256.
  - irq=1, STATUS=0x2002, CYCLES=205.
- Random mem_waitrequest of 0-3 cycles: same data result; address and data stable while stalled; CYCLES grows by the total stall count.
- acc_done never rises, TimeoutCycles=16: STATUS ERR=1, DONE=1, irq=1, no write to address 256; CLR then returns STATUS to 0.
- Second GO written during a running job: no effect; exactly one job runs; SRC written mid-job is used by the next job only.
- reset_n pulled low while in STORE: all outputs 0 immediately. After release, STATUS=0 and a fresh GO completes correctly.
- acc_done held high before START: WAIT lasts 1 cycle and the results are still copied in full.
